io_port_ctrl: RTL
=================

// Module: io_port_ctrl
// PURPOSE
//  Parametrised I/O controller between external devices and the processor core. Collects bytes
//  from IN_CH input devices over four-phase hs/ack handshakes with round-robin arbitration into an
//  input FIFO. Drains processor writes from an output FIFO to one output device over the same
//  handshake. Generalises the fixed single-channel in_dev/out_dev handshake to N channels with buffering.
// PARAMETERS
//  DATA_W      8  width of every data bus and FIFO entry
//  IN_CH       2  number of input device channels (1..8)
//  IN_DEPTH    4  input FIFO entries (power of 2, >=2)
//  OUT_DEPTH   4  output FIFO entries (power of 2, >=2)
// PORTS
//  g_clk         in   1               single clock, all logic on rising edge
//  g_clr         in   1               reset, synchronous, active-high
//  in_dev_hs     in   IN_CH           per-channel request; input_bus slice valid while high
//  in_dev_ack    out  IN_CH           per-channel acknowledge
//  input_bus     in   IN_CH*DATA_W    channel k data at [k*DATA_W +: DATA_W]
//  cpu_in_valid  out  1               input FIFO non-empty
//  cpu_rd_data   out  DATA_W          input FIFO head, show-ahead
//  cpu_rd_ch     out  clog2(IN_CH)|1  source channel of head entry
//  cpu_rd_req    in   1               pop input FIFO this cycle
//  cpu_wr_req    in   1               push cpu_wr_data to output FIFO
//  cpu_wr_data   in   DATA_W          write data
//  cpu_out_full  out  1               output FIFO full
//  wr_overflow   out  1               sticky: cpu_wr_req seen while full
//  out_dev_hs    out  1               output request; output_bus valid while high
//  out_dev_ack   in   1               output device acknowledge
//  output_bus    out  DATA_W          registered output data
// BEHAVIOUR
//  Reset (g_clr=1 at edge): all outputs 0, both FIFOs empty, RR pointer=0, FSMs idle, wr_overflow=0.
//  Reset mid-handshake aborts it. The pending byte is lost. Acks and hs drop the next cycle.
//  Input FSM, IN_IDLE/IN_ACK:
//   IN_IDLE: if any in_dev_hs high and input FIFO not full, grant the first requester at or after the RR pointer.
//   On grant: push {ch,data}, set in_dev_ack[ch]=1, RR pointer=ch+1 mod IN_CH, go to IN_ACK.
//   The ack is seen 1 cycle after hs is sampled.
//   IN_ACK: hold ack. When in_dev_hs[ch]=0, drop ack and return to IN_IDLE.
//   One channel is serviced per handshake. Other channels wait with ack low.
//   Input FIFO full: no grant, all acks stay low, devices stall. No data is lost.
//  Output FSM, OUT_IDLE/OUT_REQ/OUT_REL:
//   OUT_IDLE: if the output FIFO is non-empty, pop the head into output_bus, set out_dev_hs=1, go to OUT_REQ.
//   OUT_REQ: on out_dev_ack=1, set hs=0 and go to OUT_REL. output_bus holds its value.
//   OUT_REL: on out_dev_ack=0, go to OUT_IDLE. The next word can launch the following cycle.
//   An ack that is already high in OUT_IDLE is ignored. hs does not rise until the ack has returned to 0.
//  FIFOs:
//   Simultaneous push and pop: both happen, count unchanged. A pop on empty is ignored.
//   A simultaneous cpu_wr_req and FSM pop while full succeeds: count unchanged, cpu_out_full stays 1.
//   cpu_wr_req while full with no pop: data dropped, wr_overflow=1 until reset.
//   Pointers wrap mod depth. Count is clog2(depth)+1 bits.
//   cpu_rd_data and cpu_rd_ch are valid only while cpu_in_valid=1. Otherwise their value is undefined.
// STRUCTURE
//  Package io_pkg: in/out FSM state localparams, clog2 constant function, channel-index width macro.
//  Sub-module io_fifo #(W,DEPTH): sync show-ahead FIFO with push, pop, full, empty and count outputs.
//  io_fifo is instantiated twice: input FIFO width DATA_W+CH_W, output FIFO width DATA_W.
//  The RR arbiter and both FSMs live in io_port_ctrl.
// TESTING
//  1. Reset, then ch0 hs=1 with data 0x0A. Expect ack[0]=1 at +1 cycle, cpu_rd_data=0x0A, ch=0.
//     Then hs=0: ack=0 at +1 cycle.
//  2. ch0 and ch1 hs held high with 0x11/0x22, 4 handshakes. FIFO order is ch0,ch1,ch0,ch1 (RR fairness).
//  3. No cpu_rd_req, 5 input handshakes, IN_DEPTH=4. 4th ack given. 5th hs sees ack held 0 until one cpu_rd_req.
//     Then the 5th completes and the FIFO holds 4 entries.
//  4. cpu_wr_req 0x55 then 0xAA. output_bus=0x55 with hs=1. Ack toggle. Then output_bus=0xAA.
//     Verify hs never rises while out_dev_ack=1.
//  5. Output device never acks, 6 writes with OUT_DEPTH=4. First word is popped to the bus.
//     4 more fill the FIFO, cpu_out_full=1. 6th write sets wr_overflow=1 and its data is absent.
//  6. Assert g_clr during IN_ACK and OUT_REQ. Next cycle all acks=0, out_dev_hs=0, cpu_in_valid=0, cpu_out_full=0.

Source files
------------

// File: rtl/io_port_ctrl_pkg.sv
// Shared types and constant helpers for the I/O port controller slice.
package io_pkg;

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_REL
  } out_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Channel-index width; never narrower than one bit so a single channel still has a tag.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_port_ctrl_fifo.sv
// Synchronous show-ahead FIFO; power-of-two depth, pointers wrap naturally.
module io_fifo
  import io_pkg::*;
#(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // A push while full is accepted only when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// N-channel input collector with round-robin arbitration and a buffered single output device,
// all over four-phase hs/ack handshakes.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned IN_CH     = 2,
  parameter  int unsigned IN_DEPTH  = 4,
  parameter  int unsigned OUT_DEPTH = 4,
  localparam int unsigned CH_W      = ch_w(IN_CH)
) (
  input  logic                    g_clk,
  input  logic                    g_clr,
  input  logic [IN_CH-1:0]        in_dev_hs,
  output logic [IN_CH-1:0]        in_dev_ack,
  input  logic [IN_CH*DATA_W-1:0] input_bus,
  output logic                    cpu_in_valid,
  output logic [DATA_W-1:0]       cpu_rd_data,
  output logic [CH_W-1:0]         cpu_rd_ch,
  input  logic                    cpu_rd_req,
  input  logic                    cpu_wr_req,
  input  logic [DATA_W-1:0]       cpu_wr_data,
  output logic                    cpu_out_full,
  output logic                    wr_overflow,
  output logic                    out_dev_hs,
  input  logic                    out_dev_ack,
  output logic [DATA_W-1:0]       output_bus
);

  localparam int unsigned IN_CW  = clog2(IN_DEPTH) + 1;
  localparam int unsigned OUT_CW = clog2(OUT_DEPTH) + 1;

  // ---------------- input side ----------------
  in_state_t                in_state, in_next;
  logic [CH_W-1:0]          rr_ptr, rr_next;
  logic [CH_W-1:0]          cur_ch, cur_ch_next;
  logic [IN_CH-1:0]         ack_next;
  logic                     grant_valid;
  int unsigned              grant_idx;
  int unsigned              idx;
  logic [CH_W-1:0]          grant_ch;
  logic [DATA_W-1:0]        grant_data;
  logic                     in_push;
  logic                     in_full;
  logic                     in_empty;
  logic [DATA_W+CH_W-1:0]   in_head;
  logic [IN_CW-1:0]         in_count_unused;

  // First requester at or after the round-robin pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 0;
    idx         = 0;
    for (int unsigned i = 0; i < IN_CH; i++) begin
      idx = (32'(rr_ptr) + i) % IN_CH;
      if (!grant_valid && in_dev_hs[CH_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign grant_ch   = CH_W'(grant_idx);
  assign grant_data = DATA_W'(input_bus >> (grant_idx * DATA_W));

  always_comb begin
    in_next     = in_state;
    rr_next     = rr_ptr;
    cur_ch_next = cur_ch;
    ack_next    = in_dev_ack;
    in_push     = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (grant_valid && !in_full) begin
          in_push            = 1'b1;
          ack_next           = '0;
          ack_next[grant_ch] = 1'b1;
          cur_ch_next        = grant_ch;
          rr_next            = CH_W'((grant_idx + 1) % IN_CH);
          in_next            = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!in_dev_hs[cur_ch]) begin
          ack_next = '0;
          in_next  = IN_IDLE;
        end
      end
      default: in_next = IN_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      in_state   <= IN_IDLE;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      in_dev_ack <= '0;
    end else begin
      in_state   <= in_next;
      rr_ptr     <= rr_next;
      cur_ch     <= cur_ch_next;
      in_dev_ack <= ack_next;
    end
  end

  io_fifo #(.W(DATA_W + CH_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (g_clk),
    .clr   (g_clr),
    .push  (in_push),
    .pop   (cpu_rd_req),
    .wdata ({grant_ch, grant_data}),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count_unused)
  );

  assign cpu_in_valid = !in_empty;
  assign cpu_rd_data  = in_head[DATA_W-1:0];
  assign cpu_rd_ch    = in_head[DATA_W +: CH_W];

  // ---------------- output side ----------------
  out_state_t          out_state, out_next;
  logic                out_pop;
  logic                out_full;
  logic                out_empty;
  logic [DATA_W-1:0]   out_head;
  logic [OUT_CW-1:0]   out_count_unused;
  logic                hs_next;
  logic [DATA_W-1:0]   bus_next;

  // Launch waits for a low ack so a stale ack can never complete a fresh request.
  always_comb begin
    out_next = out_state;
    out_pop  = 1'b0;
    hs_next  = out_dev_hs;
    bus_next = output_bus;
    case (out_state)
      OUT_IDLE: begin
        if (!out_empty && !out_dev_ack) begin
          out_pop  = 1'b1;
          bus_next = out_head;
          hs_next  = 1'b1;
          out_next = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (out_dev_ack) begin
          hs_next  = 1'b0;
          out_next = OUT_REL;
        end
      end
      OUT_REL: begin
        if (!out_dev_ack) out_next = OUT_IDLE;
      end
      default: out_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      out_state   <= OUT_IDLE;
      out_dev_hs  <= 1'b0;
      output_bus  <= '0;
      wr_overflow <= 1'b0;
    end else begin
      out_state   <= out_next;
      out_dev_hs  <= hs_next;
      output_bus  <= bus_next;
      wr_overflow <= wr_overflow | (cpu_wr_req && out_full && !out_pop);
    end
  end

  io_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (g_clk),
    .clr   (g_clr),
    .push  (cpu_wr_req),
    .pop   (out_pop),
    .wdata (cpu_wr_data),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count_unused)
  );

  assign cpu_out_full = out_full;

endmodule
